// File: rtl/retire_trace_buffer.sv
// Retire trace buffer: captures retire records into a first-word-fall-through FIFO
// and keeps run counters with halt and cycle-limit timeout detection.
module retire_trace_buffer #(
  parameter int DEPTH       = 16,
  parameter int CYCLE_LIMIT = 40000
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_retire_valid,
  input  logic [31:0]              i_retire_pc,
  input  logic [31:0]              i_retire_inst,
  input  logic [4:0]               i_retire_rd_waddr,
  input  logic [31:0]              i_retire_rd_wdata,
  input  logic                     i_retire_dmem_ren,
  input  logic                     i_retire_dmem_wen,
  input  logic                     i_retire_trap,
  input  logic                     i_retire_halt,
  output logic                     o_trace_valid,
  input  logic                     i_trace_ready,
  output logic [31:0]              o_trace_pc,
  output logic [31:0]              o_trace_inst,
  output logic [4:0]               o_trace_rd_waddr,
  output logic [31:0]              o_trace_rd_wdata,
  output logic [3:0]               o_trace_flags,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic [31:0]              o_cycles,
  output logic [31:0]              o_instret,
  output logic [31:0]              o_loads,
  output logic [31:0]              o_stores,
  output logic [15:0]              o_dropped,
  output logic                     o_halted,
  output logic                     o_timeout
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 105;
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(DEPTH);
  localparam logic [31:0]      LAST_CYCLE = 32'(CYCLE_LIMIT - 1);

  typedef enum logic [1:0] {
    S_RUN,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  state_t           state;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic             run;
  logic             pop;
  logic             push;
  logic             halt_seen;
  logic [REC_W-1:0] rec_in;
  logic [REC_W-1:0] rec_head;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign run       = (state == S_RUN);
  assign pop       = (o_count != '0) & i_trace_ready;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign push      = run & i_retire_valid & ((o_count != FULL_CNT) | pop);
  // Halt is taken from any valid record, even one that the full FIFO drops.
  assign halt_seen = run & i_retire_valid & i_retire_halt;

  assign rec_in = {i_retire_halt, i_retire_trap, i_retire_dmem_wen, i_retire_dmem_ren,
                   i_retire_rd_wdata, i_retire_rd_waddr, i_retire_inst, i_retire_pc};

  always_ff @(posedge i_clk) begin
    if (push) mem[tail] <= rec_in;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_RUN;
      head      <= '0;
      tail      <= '0;
      o_count   <= '0;
      o_cycles  <= '0;
      o_instret <= '0;
      o_loads   <= '0;
      o_stores  <= '0;
      o_dropped <= '0;
      o_halted  <= 1'b0;
      o_timeout <= 1'b0;
    end else begin
      if (push) tail <= tail + PTR_W'(1);
      if (pop)  head <= head + PTR_W'(1);
      if (push && !pop)      o_count <= o_count + CNT_W'(1);
      else if (!push && pop) o_count <= o_count - CNT_W'(1);

      if (run) begin
        o_cycles <= o_cycles + 32'd1;
        if (i_retire_valid) begin
          o_instret <= o_instret + 32'd1;
          if (i_retire_dmem_ren) o_loads  <= o_loads + 32'd1;
          if (i_retire_dmem_wen) o_stores <= o_stores + 32'd1;
          if (!push)             o_dropped <= sat_inc16(o_dropped);
        end
        if (halt_seen) begin
          state    <= S_HALTED;
          o_halted <= 1'b1;
        end else if (o_cycles == LAST_CYCLE) begin
          state     <= S_TIMEOUT;
          o_timeout <= 1'b1;
        end
      end
    end
  end

  // Head is read straight from storage; fields read as zero while empty.
  assign rec_head         = mem[head];
  assign o_trace_valid    = (o_count != '0);
  assign o_trace_pc       = o_trace_valid ? rec_head[31:0]    : 32'd0;
  assign o_trace_inst     = o_trace_valid ? rec_head[63:32]   : 32'd0;
  assign o_trace_rd_waddr = o_trace_valid ? rec_head[68:64]   : 5'd0;
  assign o_trace_rd_wdata = o_trace_valid ? rec_head[100:69]  : 32'd0;
  assign o_trace_flags    = o_trace_valid ? rec_head[104:101] : 4'd0;

endmodule

// File: tb/tb_retire_trace_buffer.sv
// Bench for retire_trace_buffer: queue-based reference model, scoreboard of drained
// records and per-cycle counter comparison, directed scenarios plus random traffic.
module tb_retire_trace_buffer;
  localparam int DEPTH = 16;
  localparam int LIMIT = 50;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        retire_valid = 1'b0;
  logic [31:0] retire_pc = '0;
  logic [31:0] retire_inst = '0;
  logic [4:0]  retire_rd_waddr = '0;
  logic [31:0] retire_rd_wdata = '0;
  logic        retire_ren = 1'b0;
  logic        retire_wen = 1'b0;
  logic        retire_trap = 1'b0;
  logic        retire_halt = 1'b0;
  logic        trace_ready = 1'b0;
  logic        trace_valid;
  logic [31:0] trace_pc;
  logic [31:0] trace_inst;
  logic [4:0]  trace_rd_waddr;
  logic [31:0] trace_rd_wdata;
  logic [3:0]  trace_flags;
  logic [4:0]  count;
  logic [31:0] cycles, instret, loads, stores;
  logic [15:0] dropped;
  logic        halted, timeout;

  always #5 clk = ~clk;

  retire_trace_buffer #(.DEPTH(DEPTH), .CYCLE_LIMIT(LIMIT)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_retire_valid(retire_valid), .i_retire_pc(retire_pc), .i_retire_inst(retire_inst),
    .i_retire_rd_waddr(retire_rd_waddr), .i_retire_rd_wdata(retire_rd_wdata),
    .i_retire_dmem_ren(retire_ren), .i_retire_dmem_wen(retire_wen),
    .i_retire_trap(retire_trap), .i_retire_halt(retire_halt),
    .o_trace_valid(trace_valid), .i_trace_ready(trace_ready),
    .o_trace_pc(trace_pc), .o_trace_inst(trace_inst),
    .o_trace_rd_waddr(trace_rd_waddr), .o_trace_rd_wdata(trace_rd_wdata),
    .o_trace_flags(trace_flags), .o_count(count), .o_cycles(cycles),
    .o_instret(instret), .o_loads(loads), .o_stores(stores), .o_dropped(dropped),
    .o_halted(halted), .o_timeout(timeout)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [4:0]  rd;
    logic [31:0] wd;
    logic [3:0]  flags;
  } rec_t;

  rec_t exp_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: 0 = RUN, 1 = HALTED, 2 = TIMEOUT
  int          m_state;
  int          m_cnt;
  int          m_dropped;
  logic [31:0] m_cycles, m_instret, m_loads, m_stores;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_state = 0; m_cnt = 0; m_dropped = 0;
    m_cycles = '0; m_instret = '0; m_loads = '0; m_stores = '0;
  endtask

  task automatic model_edge();
    bit   pop, acc;
    rec_t r;
    pop = (m_cnt > 0) && trace_ready;
    acc = 1'b0;
    if (m_state == 0) begin
      if (retire_valid) begin
        m_instret = m_instret + 1;
        if (retire_ren) m_loads = m_loads + 1;
        if (retire_wen) m_stores = m_stores + 1;
        if (m_cnt < DEPTH || pop) begin
          acc = 1'b1;
          r.pc = retire_pc; r.inst = retire_inst; r.rd = retire_rd_waddr;
          r.wd = retire_rd_wdata;
          r.flags = {retire_halt, retire_trap, retire_wen, retire_ren};
          exp_q.push_back(r);
        end else if (m_dropped < 65535) begin
          m_dropped++;
        end
      end
      if (retire_valid && retire_halt) m_state = 1;
      else if (m_cycles == 32'(LIMIT - 1)) m_state = 2;
      m_cycles = m_cycles + 1;
    end
    m_cnt = m_cnt + int'(acc) - int'(pop);
  endtask

  // Scoreboard monitor: sampled on the falling edge, away from the active edge.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      check("trace_valid", {63'd0, trace_valid}, {63'd0, exp_q.size() != 0});
      if (trace_valid && exp_q.size() != 0) begin
        check("head_pc", {32'd0, trace_pc}, {32'd0, exp_q[0].pc});
        check("head_inst", {32'd0, trace_inst}, {32'd0, exp_q[0].inst});
        check("head_rd", {59'd0, trace_rd_waddr}, {59'd0, exp_q[0].rd});
        check("head_wdata", {32'd0, trace_rd_wdata}, {32'd0, exp_q[0].wd});
        check("head_flags", {60'd0, trace_flags}, {60'd0, exp_q[0].flags});
        if (trace_ready) void'(exp_q.pop_front());
      end else if (!trace_valid) begin
        check("empty_fields", {trace_pc, trace_inst[31:0]} ^ {27'd0, trace_rd_waddr, trace_rd_wdata}
              ^ {60'd0, trace_flags}, 64'd0);
      end
      check("count", {59'd0, count}, 64'(m_cnt));
      check("cycles", {32'd0, cycles}, {32'd0, m_cycles});
      check("instret", {32'd0, instret}, {32'd0, m_instret});
      check("loads", {32'd0, loads}, {32'd0, m_loads});
      check("stores", {32'd0, stores}, {32'd0, m_stores});
      check("dropped", {48'd0, dropped}, 64'(m_dropped));
      check("halted", {63'd0, halted}, {63'd0, m_state == 1});
      check("timeout", {63'd0, timeout}, {63'd0, m_state == 2});
    end
  end

  task automatic tick();
    @(posedge clk);
    if (rst === 1'b0) model_edge();
    #1;
  endtask

  task automatic idle();
    retire_valid = 1'b0; retire_ren = 1'b0; retire_wen = 1'b0;
    retire_trap = 1'b0; retire_halt = 1'b0;
  endtask

  task automatic retire(input logic [31:0] pc, input logic ren, input logic wen, input logic halt);
    retire_valid = 1'b1; retire_pc = pc; retire_inst = $urandom;
    retire_rd_waddr = 5'($urandom_range(0, 31)); retire_rd_wdata = $urandom;
    retire_ren = ren; retire_wen = wen; retire_trap = 1'b0; retire_halt = halt;
  endtask

  task automatic apply_reset();
    idle();
    #2 rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    apply_reset();
    check("rst_valid", {63'd0, trace_valid}, 64'd0);
    check("rst_cycles", {32'd0, cycles}, 64'd0);

    // In-order drain with ready held high
    trace_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin retire(32'(i * 4), 1'b0, 1'b0, 1'b0); tick(); end
    idle();
    repeat (3) tick();
    check("t1_instret", {32'd0, instret}, 64'd5);
    check("t1_count", {59'd0, count}, 64'd0);
    check("t1_dropped", {48'd0, dropped}, 64'd0);

    // Overflow with ready low, then full FIFO with simultaneous push and pop
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin retire(32'(i * 4), 1'b0, 1'b0, 1'b0); tick(); end
    check("t2_count_full", {59'd0, count}, 64'd16);
    check("t2_dropped", {48'd0, dropped}, 64'd4);
    retire(32'h100, 1'b0, 1'b0, 1'b0); trace_ready = 1'b1; tick();
    check("t2_count_pushpop", {59'd0, count}, 64'd16);
    check("t2_dropped_pushpop", {48'd0, dropped}, 64'd4);
    idle();
    repeat (18) tick();
    check("t2_drained", {59'd0, count}, 64'd0);

    // Load, store, halt; later retires ignored; halt record still drains
    apply_reset();
    trace_ready = 1'b0;
    retire(32'h200, 1'b1, 1'b0, 1'b0); tick();
    retire(32'h204, 1'b0, 1'b1, 1'b0); tick();
    retire(32'h208, 1'b0, 1'b0, 1'b1); tick();
    check("t3_halted", {63'd0, halted}, 64'd1);
    check("t3_loads", {32'd0, loads}, 64'd1);
    check("t3_stores", {32'd0, stores}, 64'd1);
    for (int i = 0; i < 3; i++) begin retire(32'h300 + 32'(i * 4), 1'b1, 1'b1, 1'b0); tick(); end
    check("t3_cycles_frozen", {32'd0, cycles}, 64'd3);
    check("t3_instret_frozen", {32'd0, instret}, 64'd3);
    idle(); trace_ready = 1'b1;
    repeat (5) tick();
    check("t3_drained", {59'd0, count}, 64'd0);

    // Timeout after LIMIT run cycles
    apply_reset();
    repeat (LIMIT) tick();
    check("t4_timeout", {63'd0, timeout}, 64'd1);
    check("t4_cycles", {32'd0, cycles}, 64'(LIMIT));
    repeat (3) tick();
    check("t4_cycles_frozen", {32'd0, cycles}, 64'(LIMIT));

    // Halt on the limit cycle wins over timeout
    apply_reset();
    repeat (LIMIT - 1) tick();
    retire(32'h400, 1'b0, 1'b0, 1'b1); tick();
    idle();
    check("t5_halted", {63'd0, halted}, 64'd1);
    check("t5_timeout", {63'd0, timeout}, 64'd0);
    check("t5_cycles", {32'd0, cycles}, 64'(LIMIT));
    repeat (2) tick();

    // Asynchronous reset between edges with 7 entries queued
    apply_reset();
    trace_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin retire(32'h500 + 32'(i * 4), 1'b1, 1'b0, 1'b0); tick(); end
    idle();
    check("t6_count_before", {59'd0, count}, 64'd7);
    #2 rst = 1'b1;
    #1;
    check("t6_valid", {63'd0, trace_valid}, 64'd0);
    check("t6_count", {59'd0, count}, 64'd0);
    check("t6_counters", {32'd0, cycles | instret | loads}, 64'd0);
    check("t6_state", {62'd0, halted, timeout}, 64'd0);
    model_reset();
    @(posedge clk); #1 rst = 1'b0;

    // Random traffic against the reference model
    for (int round = 0; round < 9; round++) begin
      int ncyc;
      apply_reset();
      ncyc = (round % 3 == 0) ? 60 : 40;
      for (int c = 0; c < ncyc; c++) begin
        retire_valid    = ($urandom_range(0, 3) != 0);
        retire_pc       = $urandom;
        retire_inst     = $urandom;
        retire_rd_waddr = 5'($urandom_range(0, 31));
        retire_rd_wdata = $urandom;
        retire_ren      = 1'($urandom_range(0, 1));
        retire_wen      = 1'($urandom_range(0, 1));
        retire_trap     = 1'($urandom_range(0, 1));
        retire_halt     = ($urandom_range(0, 59) == 0);
        trace_ready     = ($urandom_range(0, 3) < 1 + (round % 3));
        tick();
      end
      idle(); trace_ready = 1'b1;
      repeat (DEPTH + 2) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
